// File: rtl/mux_select_sequencer_pkg.sv
// Shared constants for the mux7to1 select sequencer.
//   SEQ_NUM_INPUTS : number of mux inputs scanned (select range 0..SEQ_NUM_INPUTS-1)
//   SEL_WIDTH      : width of the MuxSelect code
//   SEQ_DIV_MAX    : default rate-divider reload (1 Hz step at 50 MHz)
//   SEQ_DIV_WIDTH  : default rate-divider counter width
//   IDLE/RUN/DONE  : sequencer state encodings
package mux_select_sequencer_pkg;

   localparam int unsigned SEQ_NUM_INPUTS = 7;
   localparam int unsigned SEL_WIDTH      = 3;
   localparam int unsigned SEQ_DIV_MAX    = 49999999;
   localparam int unsigned SEQ_DIV_WIDTH  = 26;
   localparam int unsigned STATE_WIDTH    = 2;

   localparam logic [STATE_WIDTH-1:0] IDLE = 2'd0;
   localparam logic [STATE_WIDTH-1:0] RUN  = 2'd1;
   localparam logic [STATE_WIDTH-1:0] DONE = 2'd2;

endpackage

// File: rtl/mux_select_sequencer_rate_divider.sv
// Down-counting rate divider: flags one cycle in every DIV_MAX+1 enabled clocks.
//   clock, reset : clock and asynchronous active-high reset (counter -> DIV_MAX)
//   enable       : count down one per clock
//   load         : hold the counter at DIV_MAX (takes priority over enable)
//   tick_c       : combinational terminal count, high while enabled at zero
module mux_select_sequencer_rate_divider #(
   parameter int unsigned DIV_MAX   = 3,
   parameter int unsigned DIV_WIDTH = 26
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic load,
   output logic tick_c
);

   localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(DIV_MAX);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   // Left combinational so the sequencer can register tick and step the
   // select on the same edge.
   assign tick_c = enable && (cnt_q == '0);

   // Next count: reload on terminal count so the counter never underflows.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (enable) begin
         if (cnt_q == '0) begin
            cnt_d = RELOAD;
         end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_select_sequencer.sv
// Select sequencer for mux7to1: steps MuxSelect through 0..NUM_INPUTS-1 at a
// programmable rate, either once (done pulse at the end) or wrapping forever.
// Optional macro SEQ_PAUSE_EN adds a pause input that freezes a running pass.
//   clock, reset : clock and asynchronous active-high reset
//   start        : level, starts a pass when sampled in IDLE
//   continuous   : 1 = wrap to 0 at the last input, 0 = stop after one pass
//   pause        : (SEQ_PAUSE_EN only) freeze divider and select while in RUN
//   MuxSelect    : select code to mux7to1
//   tick         : one-clock pulse on each select step
//   busy         : high while in RUN
//   done         : one-clock pulse when a single pass completes
module mux_select_sequencer
   import mux_select_sequencer_pkg::*;
#(
   parameter int unsigned DIV_MAX    = SEQ_DIV_MAX,
   parameter int unsigned DIV_WIDTH  = SEQ_DIV_WIDTH,
   parameter int unsigned NUM_INPUTS = SEQ_NUM_INPUTS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 continuous,
`ifdef SEQ_PAUSE_EN
   input  logic                 pause,
`endif
   output logic [SEL_WIDTH-1:0] MuxSelect,
   output logic                 tick,
   output logic                 busy,
   output logic                 done
);

   localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_INPUTS - 1);

   logic [STATE_WIDTH-1:0] state_q, state_d;
   logic [SEL_WIDTH-1:0]   sel_q, sel_d;
   logic                   tick_q, tick_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic div_enable_c;
   logic div_load_c;
   logic div_tick_c;

   // Divider only runs in RUN; elsewhere it is parked at DIV_MAX so every
   // pass starts with a full DIV_MAX+1 period on select 0.
`ifdef SEQ_PAUSE_EN
   assign div_enable_c = (state_q == RUN) && !pause;
`else
   assign div_enable_c = (state_q == RUN);
`endif
   assign div_load_c = (state_q != RUN);

   mux_select_sequencer_rate_divider #(
      .DIV_MAX   (DIV_MAX),
      .DIV_WIDTH (DIV_WIDTH)
   ) u_rate_divider (
      .clock  (clock),
      .reset  (reset),
      .enable (div_enable_c),
      .load   (div_load_c),
      .tick_c (div_tick_c)
   );

   // Next state, select and registered status outputs.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tick_d  = 1'b0;

      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (div_tick_c) begin
               tick_d = 1'b1;
               if (sel_q == LAST_SEL) begin
                  // continuous only matters here, at the wrap point
                  if (continuous) begin
                     sel_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  sel_d = sel_q + SEL_WIDTH'(1);
               end
            end
         end
         DONE: begin
            sel_d   = '0;
            state_d = IDLE;
         end
         default: begin
            sel_d   = '0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign MuxSelect = sel_q;
   assign tick      = tick_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
